// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU issue controller: single-cycle ops, iterative shift-add mul,
// valid/ready request side and a one-entry registered result slot.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       req_ctrl_i,
  input  logic [WIDTH-1:0] req_data1_i,
  input  logic [WIDTH-1:0] req_data2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             stall_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_OR   = 4'b0000,
    OP_AND  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_MUL  = 4'b0100,
    OP_ADDI = 4'b0101,
    OP_LD   = 4'b0110,
    OP_SD   = 4'b0111,
    OP_BEQ  = 4'b1000
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [TAG_W-1:0] mul_tag;

  logic             slot_free;
  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] alu_data;
  logic             alu_zero;
  logic [WIDTH-1:0] acc_next;

  assign slot_free   = ~rsp_valid_o | rsp_ready_i;
  assign req_ready_o = (state == IDLE) & ~flush_i & slot_free;
  assign accept      = req_valid_i & req_ready_o;
  assign is_mul      = (req_ctrl_i == OP_MUL);
  assign stall_o     = req_valid_i & ~req_ready_o;
  assign busy_o      = (state != IDLE);
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_data = '0;
    alu_zero = 1'b0;
    case (req_ctrl_i)
      OP_OR:                        alu_data = req_data1_i | req_data2_i;
      OP_AND:                       alu_data = req_data1_i & req_data2_i;
      OP_ADD, OP_ADDI, OP_LD, OP_SD: alu_data = req_data1_i + req_data2_i;
      OP_SUB:                       alu_data = req_data1_i - req_data2_i;
      OP_BEQ:                       alu_zero = (req_data1_i == req_data2_i);
      default: begin
        alu_data = '0;
        alu_zero = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
      rsp_tag_o   <= '0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      mul_tag     <= '0;
    end else if (flush_i) begin
      state       <= IDLE;
      rsp_valid_o <= 1'b0;
    end else begin
      // Drain first; a load later in this block overrides it (drain+fill).
      if (rsp_valid_o && rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand   <= req_data1_i;
              mplier  <= req_data2_i;
              acc     <= '0;
              cnt     <= '0;
              mul_tag <= req_tag_i;
              state   <= MUL;
            end else begin
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= alu_data;
              rsp_zero_o  <= alu_zero;
              rsp_tag_o   <= req_tag_i;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            if (slot_free) begin
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= acc_next;
              rsp_zero_o  <= 1'b0;
              rsp_tag_o   <= mul_tag;
              state       <= IDLE;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // The slot is always free when a mul is accepted, so this is a safety net.
          if (slot_free) begin
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= acc;
            rsp_zero_o  <= 1'b0;
            rsp_tag_o   <= mul_tag;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed ops push expected responses,
// a negedge monitor pops and compares on every result handshake.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_ctrl;
  logic [31:0] req_d1;
  logic [31:0] req_d2;
  logic [4:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [4:0]  rsp_tag;
  logic        stall;
  logic        busy;

  alu_issue_ctrl #(.WIDTH(32), .TAG_W(5)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .flush_i    (flush),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_ctrl_i (req_ctrl),
    .req_data1_i(req_d1),
    .req_data2_i(req_d2),
    .req_tag_i  (req_tag),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_zero_o (rsp_zero),
    .rsp_tag_o  (rsp_tag),
    .stall_o    (stall),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic [4:0]  tag;
  } rsp_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] data;
    logic        zero;
  } vec_t;

  rsp_t sbq[$];
  rsp_t mon_e;
  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic z, input logic [4:0] t);
    rsp_t e;
    e.data = d;
    e.zero = z;
    e.tag  = t;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t);
    int  n = 0;
    bit  done = 1'b0;
    req_valid = 1'b1;
    req_ctrl  = c;
    req_d1    = a;
    req_d2    = b;
    req_tag   = t;
    while (!done && n < 100) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  task automatic wait_rsp(input int max_cycles);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_rsp_valid", rsp_valid, 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got data 0x%0h tag %0d expected no response",
                 rsp_data, rsp_tag);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_data", rsp_data, mon_e.data);
        check("rsp_zero", rsp_zero, mon_e.zero);
        check("rsp_tag", rsp_tag, mon_e.tag);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    vecs[0] = '{4'b0001, 32'h0000_00F0, 32'h0000_003C, 5'd1, 32'h0000_0030, 1'b0};
    vecs[1] = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd2, 32'h0000_0000, 1'b0};
    vecs[2] = '{4'b0110, 32'd100,       32'h0000_0020, 5'd3, 32'h0000_0084, 1'b0};
    vecs[3] = '{4'b0111, 32'h0000_1000, 32'hFFFF_FFFC, 5'd4, 32'h0000_0FFC, 1'b0};
    vecs[4] = '{4'b0011, 32'd3,         32'd10,        5'd5, 32'hFFFF_FFF9, 1'b0};
    vecs[5] = '{4'b1000, 32'd9,         32'd9,         5'd6, 32'h0000_0000, 1'b1};
    vecs[6] = '{4'b1000, 32'd9,         32'd8,         5'd7, 32'h0000_0000, 1'b0};
    vecs[7] = '{4'b1011, 32'd5,         32'd5,         5'd8, 32'h0000_0000, 1'b0};
    vecs[8] = '{4'b1111, 32'd7,         32'd7,         5'd9, 32'h0000_0000, 1'b0};
    vecs[9] = '{4'b0000, 32'h0000_0000, 32'h0000_0000, 5'd10, 32'h0000_0000, 1'b0};

    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_ctrl  = '0;
    req_d1    = '0;
    req_d2    = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_zero", rsp_zero, 1'b0);
    check("reset_rsp_tag", rsp_tag, 5'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_req_ready", req_ready, 1'b1);

    // add 5,7 tag 3: result visible right after the accept edge
    push(32'd12, 1'b0, 5'd3);
    issue(4'b0010, 32'd5, 32'd7, 5'd3);
    check("add_latency_valid", rsp_valid, 1'b1);
    check("add_latency_data", rsp_data, 32'd12);
    @(posedge clk);
    #1;
    check("add_drained", rsp_valid, 1'b0);

    // back-to-back sub then or, consumer always ready
    push(32'd7, 1'b0, 5'd10);
    push(32'hFF, 1'b0, 5'd11);
    req_valid = 1'b1;
    req_ctrl  = 4'b0011;
    req_d1    = 32'd10;
    req_d2    = 32'd3;
    req_tag   = 5'd10;
    @(negedge clk);
    check("b2b_ready_0", req_ready, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_sub_data", rsp_data, 32'd7);
    req_ctrl = 4'b0000;
    req_d1   = 32'hF0;
    req_d2   = 32'h0F;
    req_tag  = 5'd11;
    @(negedge clk);
    check("b2b_ready_1", req_ready, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_or_data", rsp_data, 32'hFF);
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      push(vecs[i].data, vecs[i].zero, vecs[i].tag);
      issue(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].tag);
    end
    @(posedge clk);
    #1;

    // mul 3 * 0xFFFFFFFE with a waiting add to observe stall
    push(32'hFFFF_FFFA, 1'b0, 5'd7);
    issue(4'b0100, 32'h0000_0003, 32'hFFFF_FFFE, 5'd7);
    push(32'd2, 1'b0, 5'd1);
    req_valid = 1'b1;
    req_ctrl  = 4'b0010;
    req_d1    = 32'd1;
    req_d2    = 32'd1;
    req_tag   = 5'd1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("mul_stall", stall, 1'b1);
      check("mul_no_early_rsp", rsp_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    check("mul_rsp_valid", rsp_valid, 1'b1);
    check("mul_rsp_data", rsp_data, 32'hFFFF_FFFA);
    check("mul_busy_done", busy, 1'b0);
    @(negedge clk);
    check("post_mul_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;

    // result held while consumer stalls; next op blocked until drain
    rsp_ready = 1'b0;
    push(32'd42, 1'b0, 5'd4);
    issue(4'b0100, 32'd6, 32'd7, 5'd4);
    wait_rsp(40);
    push(32'd4, 1'b0, 5'd5);
    req_valid = 1'b1;
    req_ctrl  = 4'b0010;
    req_d1    = 32'd2;
    req_d2    = 32'd2;
    req_tag   = 5'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_no_accept", req_ready, 1'b0);
      check("hold_stall", stall, 1'b1);
      check("hold_data_stable", rsp_data, 32'd42);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("drain_fill_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("drain_fill_valid", rsp_valid, 1'b1);
    check("drain_fill_data", rsp_data, 32'd4);
    @(posedge clk);
    #1;

    // flush at mul cycle 10: no response ever appears
    issue(4'b0100, 32'd5, 32'd5, 5'd6);
    repeat (10) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    req_ctrl  = 4'b0010;
    @(negedge clk);
    check("flush_blocks_accept", req_ready, 1'b0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush_idle", busy, 1'b0);
    check("flush_rsp_valid", rsp_valid, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("flush_no_rsp", seen, 1'b0);

    // reset mid-mul clears every registered output
    issue(4'b0100, 32'd3, 32'd4, 5'd9);
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midmul_reset_valid", rsp_valid, 1'b0);
    check("midmul_reset_data", rsp_data, 32'h0);
    check("midmul_reset_zero", rsp_zero, 1'b0);
    check("midmul_reset_tag", rsp_tag, 5'd0);
    check("midmul_reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("reset_no_rsp", rsp_valid, 1'b0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
